// File: rtl/dmi_cdc_rx.sv
// DM-side receiver for DMI requests from the JTAG DTM (tclk domain).
// The request level is synchronised, the payload captured, and completion is returned by a four-phase handshake.
module dmi_cdc_rx #(
   parameter int ABITS       = 7,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dtm_start,
   input  logic [1:0]       dtm_op,
   input  logic [ABITS-1:0] dtm_addr,
   input  logic [31:0]      dtm_wdata,
   output logic             dtm_finish,
   output logic [31:0]      dtm_rdata,
   output logic [1:0]       dtm_resp,
   output logic             dm_req_valid,
   input  logic             dm_req_ready,
   output logic [1:0]       dm_op,
   output logic [ABITS-1:0] dm_addr,
   output logic [31:0]      dm_wdata,
   input  logic             dm_resp_valid,
   input  logic [31:0]      dm_rdata,
   input  logic             dm_resp_err
);
   localparam int CW = $clog2(TIMEOUT + SYNC_STAGES) + 1;

   typedef enum logic [2:0] {ARM, IDLE, REQ, WAIT, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   start_q_reg;
   logic                   start_s, rise, timeout;
   logic [1:0]             op_reg, op_next;
   logic [ABITS-1:0]       addr_reg, addr_next;
   logic [31:0]            wdata_reg, wdata_next;
   logic [31:0]            rdata_reg, rdata_next;
   logic [1:0]             resp_reg, resp_next;
   logic                   finish_reg, finish_next;
   logic [CW-1:0]          cnt_reg, cnt_next;

   assign start_s = sync_reg[SYNC_STAGES-1];
   assign rise    = start_s & ~start_q_reg;
   assign timeout = (cnt_reg == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ARM;
         sync_reg    <= '0;
         start_q_reg <= 1'b0;
         op_reg      <= '0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         resp_reg    <= '0;
         finish_reg  <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         sync_reg    <= {sync_reg[SYNC_STAGES-2:0], dtm_start};
         start_q_reg <= start_s;
         op_reg      <= op_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         rdata_reg   <= rdata_next;
         resp_reg    <= resp_next;
         finish_reg  <= finish_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      rdata_next  = rdata_reg;
      resp_next   = resp_reg;
      cnt_next    = cnt_reg;
      finish_next = (state_reg == DONE) && start_s;
      case (state_reg)
         // The chain is cleared by reset, so start_s is only trusted once it has refilled.
         ARM: begin
            if (cnt_reg == CW'(SYNC_STAGES)) begin
               if (!start_s) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         IDLE: begin
            if (rise) begin
               op_next    = dtm_op;
               addr_next  = dtm_addr;
               wdata_next = dtm_wdata;
               rdata_next = '0;
               resp_next  = 2'd0;
               cnt_next   = '0;
               case (dtm_op)
                  2'd0:    state_next = DONE;
                  2'd3: begin
                     resp_next  = 2'd2;
                     state_next = DONE;
                  end
                  default: state_next = REQ;
               endcase
            end
         end
         REQ: begin
            cnt_next = cnt_reg + 1'b1;
            if (dm_req_ready && dm_resp_valid) begin
               rdata_next = (op_reg == 2'd1) ? dm_rdata : 32'd0;
               resp_next  = dm_resp_err ? 2'd2 : 2'd0;
               state_next = DONE;
            end else if (timeout) begin
               rdata_next = '0;
               resp_next  = 2'd2;
               state_next = DONE;
            end else if (dm_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            cnt_next = cnt_reg + 1'b1;
            if (dm_resp_valid) begin
               rdata_next = (op_reg == 2'd1) ? dm_rdata : 32'd0;
               resp_next  = dm_resp_err ? 2'd2 : 2'd0;
               state_next = DONE;
            end else if (timeout) begin
               rdata_next = '0;
               resp_next  = 2'd2;
               state_next = DONE;
            end
         end
         DONE: begin
            if (!start_s) state_next = IDLE;
         end
         default: state_next = ARM;
      endcase
   end

   assign dtm_finish   = finish_reg;
   assign dtm_rdata    = rdata_reg;
   assign dtm_resp     = resp_reg;
   assign dm_req_valid = (state_reg == REQ);
   assign dm_op        = op_reg;
   assign dm_addr      = addr_reg;
   assign dm_wdata     = wdata_reg;
endmodule

// File: doc/dmi_cdc_rx.md
Name: dmi_cdc_rx

Overview:
- DM-side receiver for DMI requests from the JTAG DTM, which runs in the tclk domain.
- Samples the DTM's level-held request in the `clk` domain through a synchronizer and captures the stable payload.
- Issues a valid/ready request to the debug module and returns data/status to the DTM by four-phase handshake (start↑ → finish↑ → start↓ → finish↓).
- Replaces the raw two-flop struct synchronizers between `dtm_jtag` and `dm`.

Parameters:
- ABITS, 7, DMI address width.
- SYNC_STAGES, 2, flops in the `dtm_start` synchronizer chain (min 2).
- TIMEOUT, 1024, `clk` cycles to wait for `dm_resp_valid` before failing the request.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- dtm_start  in  1  DTM request level, asynchronous to `clk`, held high until `dtm_finish` is seen
- dtm_op  in  2  DMI op (0 nop, 1 read, 2 write, 3 reserved); stable while `dtm_start` is high
- dtm_addr  in  ABITS  DMI address; stable while `dtm_start` is high
- dtm_wdata  in  32  write data; stable while `dtm_start` is high
- dtm_finish  out  1  completion level toward DTM (registered)
- dtm_rdata  out  32  response data; valid while `dtm_finish` is high
- dtm_resp  out  2  DMI status: 0 success, 2 failed
- dm_req_valid  out  1  request to DM
- dm_req_ready  in  1  DM accepts request
- dm_op  out  2  captured op (1 or 2 only)
- dm_addr  out  ABITS  captured address
- dm_wdata  out  32  captured write data
- dm_resp_valid  in  1  one-cycle DM response strobe
- dm_rdata  in  32  DM read data, qualified by `dm_resp_valid`
- dm_resp_err  in  1  DM error flag, qualified by `dm_resp_valid`

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All outputs, synchronizer flops, captured registers and timeout counter clear to 0.
  - State → ARM.
- `start_s` is the last synchronizer stage; `start_q` is `start_s` delayed one cycle; rise = start_s & ~start_q.
- ARM: wait for `start_s`=0, then → IDLE. This prevents re-executing a request that was already pending across a reset.
- IDLE: on rise, capture `dtm_op`/`dtm_addr`/`dtm_wdata` into registers. The payload has been stable for at least SYNC_STAGES cycles.
  - op==0: `dtm_rdata`=0, `dtm_resp`=0 → DONE.
  - op==3: `dtm_rdata`=0, `dtm_resp`=2 → DONE.
  - op==1 or 2: → REQ.
- REQ:
  - `dm_req_valid`=1 with captured fields, starting the cycle after the capture edge.
  - `dm_op`/`dm_addr`/`dm_wdata` stay constant while valid is high.
  - Handshake completes on valid & ready at posedge; valid drops the next cycle → WAIT.
  - The timeout counter runs from REQ entry.
- WAIT: on `dm_resp_valid`:
  - `dtm_rdata` ← `dm_rdata` for reads, 0 for writes.
  - `dtm_resp` ← err ? 2 : 0.
  - → DONE.
  - A `dm_resp_valid` arriving in the same cycle as the REQ handshake is accepted (REQ → DONE directly).
- Timeout: counter reaching TIMEOUT-1 in REQ or WAIT → `dm_req_valid`=0, `dtm_rdata`=0, `dtm_resp`=2 → DONE. A `dm_resp_valid` in the timeout cycle takes priority over the timeout.
- DONE:
  - `dtm_finish`=1 (registered, asserted the cycle after entry).
  - `dtm_rdata`/`dtm_resp` are held constant.
  - When `start_s`=0, `dtm_finish` → 0 on the next clk and → IDLE.
  - `dtm_rdata`/`dtm_resp` keep their values until the next capture.
- Stray `dm_resp_valid` in IDLE/ARM/DONE/REQ (before the handshake): ignored.
- `dtm_start` dropping before DONE is a protocol violation. The block completes the transaction and then leaves DONE immediately.
- One outstanding request at a time. No new rise is accepted outside IDLE.

Test Plan:
- Reset with `dtm_start`=1 held: no `dm_req_valid` ever. Drop start, then raise it with op=1, addr=0x10 → exactly one request.
- Read: op=1, addr=0x11, DM ready=1, resp after 3 cycles with rdata=0xDEADBEEF, err=0.
  - Expect `dtm_finish`=1, `dtm_rdata`=0xDEADBEEF, `dtm_resp`=0.
  - `dtm_finish` clears within SYNC_STAGES+2 clk after start drops.
- Write: op=2, addr=0x10, wdata=0x80000000, ready held low for 5 cycles.
  - `dm_req_valid` stays high with constant fields and drops after the handshake.
  - err=1 → `dtm_resp`=2, `dtm_rdata`=0.
- Nop (op=0) and reserved (op=3): no `dm_req_valid`. Responses are `dtm_resp`=0 and 2 respectively, with `dtm_finish` asserted.
- Timeout, TIMEOUT=16, DM never responds: `dtm_resp`=2 exactly 16 cycles after REQ entry. A late `dm_resp_valid` after that is ignored.
- Back-to-back: 4 reads with random tclk/clk ratios (1:1 through 1:18) → 4 requests, 4 finishes, no duplicates, data matched in order.
